// File: rtl/execute_muldiv.sv
// execute_muldiv: multi-cycle RV M-extension unit; fixed-latency multiply, restoring divide,
// one operation in flight, result held on a registered MEM_* port until downstream accepts.
// state | meaning
// IDLE  | ready for a new operation
// MUL   | waiting out the multiply latency
// DIV   | restoring divide, one quotient bit per cycle, then sign fix
// DONE  | result held on MEM_* until MEM_Stall drops
module execute_muldiv #(
  parameter int XLEN       = 64,
  parameter int MUL_STAGES = 2
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            EXE_V,
  input  logic [2:0]      EXE_Op,
  input  logic [XLEN-1:0] EXE_ALU1,
  input  logic [XLEN-1:0] EXE_ALU2,
  input  logic [4:0]      EXE_DR,
  input  logic            EXE_Flush,
  input  logic            MEM_Stall,
  output logic            EXE_Ready,
  output logic            MEM_V,
  output logic [XLEN-1:0] MEM_RES,
  output logic [4:0]      MEM_DR
);
  localparam int CW = $clog2(XLEN + 1);
  localparam int PW = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state;
  logic            armed;
  logic [CW-1:0]   cnt;
  logic [1:0]      op_q;
  logic [4:0]      dr_q;
  logic [XLEN-1:0] a_q, b_q, dvs_q, quo_q, rem_q;
  logic            special_q;

  logic                   a_sgn, b_sgn;
  logic signed [XLEN:0]   a_ext, b_ext;
  logic [PW-1:0]          prod;
  logic [XLEN-1:0]        mul_res;
  logic [XLEN:0]          shifted;
  logic [XLEN-1:0]        diff;
  logic                   ge;
  logic                   div_signed, q_neg, r_neg;
  logic [XLEN-1:0]        div_res, special_res;
  logic                   in_signed, in_zero, in_ovf;
  logic [XLEN-1:0]        a_mag, b_mag;

  assign EXE_Ready = (state == IDLE);

  // Operand sign-extension selects MUL/MULH (s*s), MULHSU (s*u), MULHU (u*u).
  assign a_sgn   = (op_q != 2'd3);
  assign b_sgn   = (op_q == 2'd1);
  assign a_ext   = {a_sgn & a_q[XLEN-1], a_q};
  assign b_ext   = {b_sgn & b_q[XLEN-1], b_q};
  assign prod    = PW'(a_ext * b_ext);
  assign mul_res = (op_q == 2'd0) ? prod[XLEN-1:0] : prod[PW-1:XLEN];

  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign ge      = (shifted >= {1'b0, dvs_q});
  assign diff    = shifted[XLEN-1:0] - dvs_q;

  assign div_signed = ~op_q[0];
  assign q_neg      = div_signed & (a_q[XLEN-1] ^ b_q[XLEN-1]);
  assign r_neg      = div_signed & a_q[XLEN-1];

  always_comb begin
    div_res = '0;
    if (op_q[1]) div_res = r_neg ? -rem_q : rem_q;
    else         div_res = q_neg ? -quo_q : quo_q;
  end

  // Divide-by-zero and signed overflow bypass the iteration entirely.
  always_comb begin
    special_res = '0;
    if (b_q == '0) special_res = op_q[1] ? a_q : '1;
    else           special_res = op_q[1] ? '0  : a_q;
  end

  assign in_signed = ~EXE_Op[0];
  assign in_zero   = (EXE_ALU2 == '0);
  assign in_ovf    = in_signed && (EXE_ALU1 == {1'b1, {(XLEN-1){1'b0}}}) && (&EXE_ALU2);
  assign a_mag     = (in_signed & EXE_ALU1[XLEN-1]) ? -EXE_ALU1 : EXE_ALU1;
  assign b_mag     = (in_signed & EXE_ALU2[XLEN-1]) ? -EXE_ALU2 : EXE_ALU2;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      armed     <= 1'b0;
      cnt       <= '0;
      op_q      <= '0;
      dr_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      dvs_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      special_q <= 1'b0;
      MEM_V     <= 1'b0;
      MEM_RES   <= '0;
      MEM_DR    <= '0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          // armed blocks acceptance on the edge that releases reset
          if (armed && EXE_V && !EXE_Flush) begin
            op_q  <= EXE_Op[1:0];
            dr_q  <= EXE_DR;
            a_q   <= EXE_ALU1;
            b_q   <= EXE_ALU2;
            quo_q <= a_mag;
            dvs_q <= b_mag;
            rem_q <= '0;
            if (EXE_Op[2]) begin
              state     <= DIV;
              cnt       <= CW'(XLEN);
              special_q <= in_zero | in_ovf;
            end else begin
              state     <= MUL;
              cnt       <= CW'(MUL_STAGES - 1);
              special_q <= 1'b0;
            end
          end
        end
        MUL: begin
          if (EXE_Flush) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state   <= DONE;
            MEM_V   <= 1'b1;
            MEM_RES <= mul_res;
            MEM_DR  <= dr_q;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DIV: begin
          if (EXE_Flush) begin
            state <= IDLE;
          end else if (special_q) begin
            state   <= DONE;
            MEM_V   <= 1'b1;
            MEM_RES <= special_res;
            MEM_DR  <= dr_q;
          end else if (cnt == '0) begin
            state   <= DONE;
            MEM_V   <= 1'b1;
            MEM_RES <= div_res;
            MEM_DR  <= dr_q;
          end else begin
            quo_q <= {quo_q[XLEN-2:0], ge};
            rem_q <= ge ? diff : shifted[XLEN-1:0];
            cnt   <= cnt - CW'(1);
          end
        end
        DONE: begin
          if (EXE_Flush || !MEM_Stall) begin
            state <= IDLE;
            MEM_V <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_execute_muldiv.sv
// Bench for execute_muldiv: arithmetic/latency model checked every cycle, plus directed
// vectors with hand-computed results, stall, flush and reset scenarios.
module tb_execute_muldiv;
  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        EXE_V;
  logic [2:0]  EXE_Op;
  logic [63:0] EXE_ALU1, EXE_ALU2;
  logic [4:0]  EXE_DR;
  logic        EXE_Flush;
  logic        MEM_Stall;
  logic        EXE_Ready;
  logic        MEM_V;
  logic [63:0] MEM_RES;
  logic [4:0]  MEM_DR;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  execute_muldiv #(.XLEN(64), .MUL_STAGES(2)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .EXE_V(EXE_V), .EXE_Op(EXE_Op),
    .EXE_ALU1(EXE_ALU1), .EXE_ALU2(EXE_ALU2), .EXE_DR(EXE_DR),
    .EXE_Flush(EXE_Flush), .MEM_Stall(MEM_Stall), .EXE_Ready(EXE_Ready),
    .MEM_V(MEM_V), .MEM_RES(MEM_RES), .MEM_DR(MEM_DR)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  localparam logic [63:0] MOST_NEG = 64'h8000_0000_0000_0000;

  function automatic logic [63:0] model_result(input logic [2:0] op, input logic [63:0] a,
                                               input logic [63:0] b);
    logic signed [127:0] sa, sb, ua, ub, p;
    longint s1, s2;
    longint unsigned u1, u2;
    logic ovf;
    logic [63:0] r;
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    ua = {64'd0, a};
    ub = {64'd0, b};
    s1 = a; s2 = b; u1 = a; u2 = b;
    ovf = (a == MOST_NEG) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    r = '0;
    case (op)
      3'd0: begin p = sa * sb; r = p[63:0];   end
      3'd1: begin p = sa * sb; r = p[127:64]; end
      3'd2: begin p = sa * ub; r = p[127:64]; end
      3'd3: begin p = ua * ub; r = p[127:64]; end
      3'd4: if (b == 0) r = '1; else if (ovf) r = a;   else r = s1 / s2;
      3'd5: if (b == 0) r = '1; else r = u1 / u2;
      3'd6: if (b == 0) r = a;  else if (ovf) r = '0;  else r = s1 % s2;
      default: if (b == 0) r = a; else r = u1 % u2;
    endcase
    return r;
  endfunction

  function automatic int model_latency(input logic [2:0] op, input logic [63:0] a,
                                       input logic [63:0] b);
    if (!op[2]) return 2;
    if (b == 0) return 1;
    if (!op[0] && a == MOST_NEG && b == 64'hFFFF_FFFF_FFFF_FFFF) return 1;
    return 65;
  endfunction

  // Behavioural model: one op in flight, countdown to result, hold while stalled.
  logic        m_busy, m_valid, m_armed;
  logic [63:0] m_res, p_res;
  logic [4:0]  m_dr, p_dr;
  int          m_cnt;

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_busy = 0; m_valid = 0; m_armed = 0; m_res = '0; m_dr = '0; m_cnt = 0;
    end else if (!m_armed) begin
      m_armed = 1;
    end else if (!m_busy) begin
      if (EXE_V && !EXE_Flush) begin
        m_busy = 1;
        m_cnt  = model_latency(EXE_Op, EXE_ALU1, EXE_ALU2);
        p_res  = model_result(EXE_Op, EXE_ALU1, EXE_ALU2);
        p_dr   = EXE_DR;
      end
    end else if (EXE_Flush) begin
      m_busy = 0; m_valid = 0;
    end else if (m_valid) begin
      if (!MEM_Stall) begin m_busy = 0; m_valid = 0; end
    end else begin
      m_cnt--;
      if (m_cnt == 0) begin m_valid = 1; m_res = p_res; m_dr = p_dr; end
    end
  end

  always @(negedge CLK) begin
    check("ready", 64'(EXE_Ready), 64'(!m_busy));
    check("valid", 64'(MEM_V), 64'(m_valid));
    check("res",   MEM_RES, m_res);
    check("dr",    64'(MEM_DR), 64'(m_dr));
  end

  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] dr, input logic [63:0] exp_res, input int exp_lat,
                       input int stall);
    int n;
    int g;
    check("model_pin", model_result(op, a, b), exp_res);
    @(negedge CLK);
    g = 0;
    while (!EXE_Ready && g < 200) begin @(negedge CLK); g++; end
    check("ready_before_issue", 64'(EXE_Ready), 64'd1);
    EXE_V = 1; EXE_Op = op; EXE_ALU1 = a; EXE_ALU2 = b; EXE_DR = dr;
    @(posedge CLK);
    @(negedge CLK);
    EXE_V = 0;
    MEM_Stall = (stall > 0);
    n = 0;
    while (n < 200) begin
      @(posedge CLK); #1;
      n++;
      if (MEM_V) break;
    end
    check("latency", 64'(n), 64'(exp_lat));
    check("result", MEM_RES, exp_res);
    check("tag", 64'(MEM_DR), 64'(dr));
    if (stall > 0) begin
      repeat (stall) @(negedge CLK);
      check("stall_ready", 64'(EXE_Ready), 64'd0);
      check("stall_valid", 64'(MEM_V), 64'd1);
      check("stall_res", MEM_RES, exp_res);
      MEM_Stall = 0;
    end
  endtask

  task automatic count_valid(input int cycles, input string name);
    int nv;
    nv = 0;
    repeat (cycles) begin @(negedge CLK); if (MEM_V) nv++; end
    check(name, 64'(nv), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    RESET_N = 0; EXE_V = 1; EXE_Op = 3'd0; EXE_ALU1 = 64'd3; EXE_ALU2 = 64'd5;
    EXE_DR = 5'd1; EXE_Flush = 0; MEM_Stall = 0;
    repeat (3) @(negedge CLK);
    @(posedge CLK);
    RESET_N = 1;
    @(negedge CLK);
    EXE_V = 0;
    check("release_edge_no_accept", 64'(EXE_Ready), 64'd1);
    count_valid(6, "release_no_valid");

    issue(3'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFC, 5'd3, 64'hFFFF_FFFF_FFFF_FFF4, 2, 0);
    issue(3'd3, '1, '1, 5'd4, 64'hFFFF_FFFF_FFFF_FFFE, 2, 0);
    issue(3'd1, '1, '1, 5'd5, 64'd0, 2, 0);
    issue(3'd2, '1, '1, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0);
    issue(3'd1, 64'h4000_0000_0000_0000, 64'd4, 5'd7, 64'd1, 2, 3);
    issue(3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd8, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
    issue(3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    issue(3'd5, 64'd5, 64'd0, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    issue(3'd7, 64'd5, 64'd0, 5'd11, 64'd5, 1, 0);
    issue(3'd6, 64'd5, 64'd0, 5'd12, 64'd5, 1, 0);
    issue(3'd4, 64'd5, 64'd0, 5'd13, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    issue(3'd4, MOST_NEG, '1, 5'd14, MOST_NEG, 1, 0);
    issue(3'd6, MOST_NEG, '1, 5'd15, 64'd0, 1, 0);
    issue(3'd5, 64'd100, 64'd7, 5'd16, 64'd14, 65, 3);
    issue(3'd7, 64'd100, 64'd7, 5'd17, 64'd2, 65, 0);
    issue(3'd4, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd18, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
    issue(3'd6, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd19, 64'd1, 65, 0);
    issue(3'd5, MOST_NEG, '1, 5'd20, 64'd0, 65, 0);
    issue(3'd7, MOST_NEG, '1, 5'd21, MOST_NEG, 65, 0);

    // Valid with flush in IDLE is not an accept
    @(negedge CLK);
    EXE_V = 1; EXE_Flush = 1; EXE_Op = 3'd0; EXE_ALU1 = 64'd9; EXE_ALU2 = 64'd9; EXE_DR = 5'd22;
    @(negedge CLK);
    EXE_V = 0; EXE_Flush = 0;
    check("idle_flush_not_accepted", 64'(EXE_Ready), 64'd1);
    count_valid(4, "idle_flush_no_valid");

    // Flush around iteration 20 of a divide
    EXE_V = 1; EXE_Op = 3'd5; EXE_ALU1 = 64'd1000; EXE_ALU2 = 64'd3; EXE_DR = 5'd23;
    @(posedge CLK);
    @(negedge CLK);
    EXE_V = 0;
    repeat (19) @(negedge CLK);
    EXE_Flush = 1;
    @(negedge CLK);
    EXE_Flush = 0;
    check("flush_back_to_idle", 64'(EXE_Ready), 64'd1);
    count_valid(80, "flush_no_valid");

    // Reset pulse mid-multiply
    EXE_V = 1; EXE_Op = 3'd0; EXE_ALU1 = 64'd6; EXE_ALU2 = 64'd7; EXE_DR = 5'd24;
    @(posedge CLK);
    @(negedge CLK);
    EXE_V = 0;
    #2 RESET_N = 0;
    @(negedge CLK);
    check("reset_ready", 64'(EXE_Ready), 64'd1);
    check("reset_res", MEM_RES, 64'd0);
    #2 RESET_N = 1;
    count_valid(10, "reset_no_valid");

    issue(3'd0, 64'd6, 64'd7, 5'd25, 64'd42, 2, 0);
    repeat (3) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/execute_muldiv.md
EXECUTE_MULDIV -- requirements
Module: execute_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 64, operand and result width (32 or 64).
REQ-002 SHALL have parameter MUL_STAGES, default 2, multiply latency in cycles (1..4).
REQ-003 SHALL have port CLK  input  1  rising-edge clock; one clock only.
REQ-004 SHALL have port RESET_N  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port EXE_V  input  1  operation valid.
REQ-006 SHALL have port EXE_Op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 SHALL have ports EXE_ALU1, EXE_ALU2  input  XLEN  rs1/rs2 operands.
REQ-008 SHALL have port EXE_DR  input  5  destination register tag.
REQ-009 SHALL have port EXE_Flush  input  1  abort in-flight operation.
REQ-010 SHALL have port MEM_Stall  input  1  downstream not accepting.
REQ-011 SHALL have port EXE_Ready  output  1  operation accepted when EXE_V && EXE_Ready.
REQ-012 SHALL have ports MEM_V (1), MEM_RES (XLEN), MEM_DR (5)  output  registered result, valid, tag.

Function
REQ-013 SHALL implement FSM IDLE, MUL, DIV, DONE; EXE_Ready = 1 only in IDLE.
REQ-014 Accept (IDLE, EXE_V=1, EXE_Flush=0) SHALL latch operands, EXE_Op, EXE_DR; go to MUL (Op<4) or DIV (Op>=4).
REQ-015 MUL SHALL count MUL_STAGES cycles, enter DONE; MEM_V rises MUL_STAGES edges after accept edge.
REQ-016 MUL result SHALL be low XLEN bits of the 2*XLEN signed product; MULH/MULHSU/MULHU SHALL be the high XLEN bits of signed*signed, signed*unsigned, unsigned*unsigned products.
REQ-017 DIV divide-by-zero SHALL go to DONE in 1 cycle: quotient all ones, remainder = ALU1 (both signed and unsigned).
REQ-018 DIV/REM signed overflow (ALU1 = most-negative, ALU2 = -1) SHALL go to DONE in 1 cycle: quotient = ALU1, remainder = 0.
REQ-019 Otherwise DIV SHALL run restoring division on magnitudes, 1 quotient bit per cycle, XLEN iterations, plus 1 sign-fix cycle; MEM_V rises XLEN+1 edges after accept.
REQ-020 Signed quotient SHALL be truncated toward zero; remainder SHALL carry dividend's sign.
REQ-021 DONE SHALL hold MEM_V=1 with MEM_RES, MEM_DR stable while MEM_Stall=1; on MEM_Stall=0 -> IDLE, MEM_V=0 next cycle.
REQ-022 No new op SHALL be accepted in DONE (no back-to-back issue; one bubble minimum between results).
REQ-023 EXE_Flush=1 in MUL, DIV or DONE SHALL return to IDLE next edge with MEM_V=0; flush has priority over completion and acceptance.
REQ-024 MEM_RES and MEM_DR SHALL change only on entry to DONE.

Reset
REQ-025 RESET_N=0 SHALL asynchronously force IDLE, MEM_V=0, MEM_RES=0, MEM_DR=0, iteration counter=0; EXE_Ready=1 while in reset.
REQ-026 Reset mid-operation SHALL discard the operation; no MEM_V after deassertion.
REQ-027 Operation SHALL not be accepted on the edge coincident with RESET_N deassertion.

Verification (XLEN=64, MUL_STAGES=2)
REQ-028 MUL 3 * -4 -> MEM_RES=0xFFFFFFFFFFFFFFF4, MEM_V 2 edges after accept.
REQ-029 MULHU 0xFFFFFFFFFFFFFFFF * 0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFE; MULH same operands -> 0.
REQ-030 DIV -7/2 -> 0xFFFFFFFFFFFFFFFD, REM -7/2 -> 0xFFFFFFFFFFFFFFFF, MEM_V 65 edges after accept.
REQ-031 DIVU 5/0 -> 0xFFFFFFFFFFFFFFFF, REM 5/0 -> 5; DIV 0x8000000000000000/-1 -> 0x8000000000000000, REM -> 0; each 1-cycle latency.
REQ-032 MEM_Stall=1 for 3 cycles in DONE -> MEM_V, MEM_RES, MEM_DR stable, EXE_Ready=0; release -> IDLE, next op accepted.
REQ-033 EXE_Flush at iteration 20 of DIV, then RESET_N pulse mid-MUL -> IDLE, no MEM_V either case.
